io_input_debounce: RTL

Synchronizes and debounces the two raw 10-bit switch/key ports before they are presented as `in_port0`/`in_port1` to the input-register stage of the pipelined CPU's I/O subsystem. Each port passes through a 2-flop synchronizer, then a whole-vector stability filter. A new value is forwarded only after it has been stable for `DB_CYCLES` consecutive clocks. A one-cycle change pulse per port is also produced for later interrupt or status use.

---
 rtl/io_pkg.sv | 23 ++
 rtl/io_debounce_port.sv | 70 +++++++
 rtl/io_input_debounce.sv | 52 +++++
 3 files changed

// File: rtl/io_pkg.sv
// -----------------------------------------------------------------------------
// io_pkg
// Shared constants for the CPU I/O subsystem's input path.
//   IO_PORT_WIDTH        : bits per raw switch/key bank
//   IO_DB_CYCLES_DEFAULT : default debounce length in io_clk cycles. Board
//                          builds override this to roughly 20 ms of cycles.
//   IO_DB_CNT_W          : stability counter width for the default length
//   db_cnt_w()           : counter width for any legal debounce length
// -----------------------------------------------------------------------------
package io_pkg;

  localparam int IO_PORT_WIDTH        = 10;
  localparam int IO_DB_CYCLES_DEFAULT = 4;

  // A length of 2 needs one counter bit. $clog2 already gives at least 1 for
  // every legal length; the floor only protects a misconfigured instance.
  function automatic int db_cnt_w(input int db_cycles);
    return ($clog2(db_cycles) < 1) ? 1 : $clog2(db_cycles);
  endfunction

  localparam int IO_DB_CNT_W = db_cnt_w(IO_DB_CYCLES_DEFAULT);

endpackage : io_pkg

// File: rtl/io_debounce_port.sv
// -----------------------------------------------------------------------------
// io_debounce_port
// Debounces one asynchronous switch bank. The bank is synchronized by two
// flops, and then a whole-vector stability filter is applied. A new value is
// committed to db_out only after it has been stable for DB_CYCLES consecutive
// clocks. chg pulses for the first cycle of each newly committed value.
//   io_clk : clock
//   resetn : asynchronous active-low reset, clears every register
//   raw    : asynchronous input bank (WIDTH bits)
//   db_out : debounced, registered value
//   chg    : one-cycle pulse that is aligned with a new db_out value
// -----------------------------------------------------------------------------
module io_debounce_port
  import io_pkg::*;
#(
  parameter int WIDTH     = IO_PORT_WIDTH,
  parameter int DB_CYCLES = IO_DB_CYCLES_DEFAULT
) (
  input  logic             io_clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] db_out,
  output logic             chg
);

  localparam int               CNT_W   = db_cnt_w(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;

  // NOTE: all state uses non-blocking assignments. Each register therefore
  // samples the pre-edge value of its neighbour, which is what makes sync1 ->
  // sync2 a real two-stage synchronizer rather than a single flop.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      cnt    <= '0;
      db_out <= '0;
      chg    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        // Any bit differing restarts the count for the whole bank.
        cand <= sync2;
        cnt  <= '0;
        chg  <= 1'b0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
        chg <= 1'b0;
      end else begin
        // The counter saturates here. A glitch that returns to the committed
        // value arrives with cand == db_out, so there is nothing to commit and
        // no pulse is issued.
        if (db_out != cand) begin
          db_out <= cand;
          chg    <= 1'b1;
        end else begin
          chg <= 1'b0;
        end
      end
    end
  end

endmodule : io_debounce_port

// File: rtl/io_input_debounce.sv
// -----------------------------------------------------------------------------
// io_input_debounce
// Synchronizes and debounces both raw switch banks before they reach the CPU
// input-register stage. Each bank is filtered independently.
//   io_clk    : clock shared with the input-register stage
//   resetn    : asynchronous active-low reset
//   raw_port0 : asynchronous switch bank 0
//   raw_port1 : asynchronous switch bank 1
//   in_port0  : debounced bank 0
//   in_port1  : debounced bank 1
//   chg0      : one-cycle pulse when in_port0 takes a new value
//   chg1      : one-cycle pulse when in_port1 takes a new value
// -----------------------------------------------------------------------------
module io_input_debounce
  import io_pkg::*;
#(
  parameter int WIDTH     = IO_PORT_WIDTH,
  parameter int DB_CYCLES = IO_DB_CYCLES_DEFAULT
) (
  input  logic             io_clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] raw_port0,
  input  logic [WIDTH-1:0] raw_port1,
  output logic [WIDTH-1:0] in_port0,
  output logic [WIDTH-1:0] in_port1,
  output logic             chg0,
  output logic             chg1
);

  io_debounce_port #(
    .WIDTH     (WIDTH),
    .DB_CYCLES (DB_CYCLES)
  ) u_port0 (
    .io_clk (io_clk),
    .resetn (resetn),
    .raw    (raw_port0),
    .db_out (in_port0),
    .chg    (chg0)
  );

  io_debounce_port #(
    .WIDTH     (WIDTH),
    .DB_CYCLES (DB_CYCLES)
  ) u_port1 (
    .io_clk (io_clk),
    .resetn (resetn),
    .raw    (raw_port1),
    .db_out (in_port1),
    .chg    (chg1)
  );

endmodule : io_input_debounce
